// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between I-side (req0) and D-side (req1).
// Latency: grant registered one cycle after cs; completion rdata/rvalid pass through combinationally.
// Backpressure: one transaction in flight; losers stay pending until IDLE after a forced DONE gap cycle.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              req0_cs_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic              req0_we_i,
    output logic [DATA_W-1:0] req0_rdata_o,
    output logic              req0_rvalid_o,

    input  logic              req1_cs_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic              req1_we_i,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic              req1_rvalid_o,

    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              cs_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rvalid_i,

    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [1:0]          r_grant;
    logic                r_last;      // index of the most recent winner
    logic                w_load;
    logic                w_win;
    logic [1:0]          w_grant_nxt;
    logic                w_in_busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_win       = 1'b0;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (req0_cs_i || req1_cs_i) begin
                    // On a tie the requester that did not win last time goes first.
                    w_win       = (req0_cs_i && req1_cs_i) ? ~r_last : req1_cs_i;
                    w_load      = 1'b1;
                    w_grant_nxt = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rvalid_i) begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_grant <= w_grant_nxt;
            if (w_load) begin
                r_addr  <= w_win ? req1_addr_i  : req0_addr_i;
                r_wdata <= w_win ? req1_wdata_i : req0_wdata_i;
                r_we    <= w_win ? req1_we_i    : req0_we_i;
                r_last  <= w_win;
            end
        end
    end

    assign w_in_busy = (r_state == ST_BUSY);

    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign we_o    = r_we;
    assign cs_o    = w_in_busy;
    assign grant_o = r_grant;
    assign busy_o  = (r_state != ST_IDLE);

    // Completions outside BUSY are stray and never reach a requester.
    assign req0_rvalid_o = rvalid_i & w_in_busy & r_grant[0];
    assign req1_rvalid_o = rvalid_i & w_in_busy & r_grant[1];
    assign req0_rdata_o  = r_grant[0] ? rdata_i : '0;
    assign req1_rdata_o  = r_grant[1] ? rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic.
// Expected outputs come from a transaction-level model (owner / gap counter / last winner).
// Requesters hold cs until their completion; the memory side pulses rvalid at random, including stray pulses.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req0_cs_i, req0_we_i, req1_cs_i, req1_we_i;
    logic [AW-1:0] req0_addr_i, req1_addr_i;
    logic [DW-1:0] req0_wdata_i, req1_wdata_i;
    logic [DW-1:0] req0_rdata_o, req1_rdata_o;
    logic          req0_rvalid_o, req1_rvalid_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          we_o, cs_o;
    logic [DW-1:0] rdata_i;
    logic          rvalid_i;
    logic [1:0]    grant_o;
    logic          busy_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_owner = -1 when nothing in flight, m_gap = 1 during the post-completion cycle.
    int            m_owner, m_gap, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_cs_i(req0_cs_i), .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
        .req0_we_i(req0_we_i), .req0_rdata_o(req0_rdata_o), .req0_rvalid_o(req0_rvalid_o),
        .req1_cs_i(req1_cs_i), .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
        .req1_we_i(req1_we_i), .req1_rdata_o(req1_rdata_o), .req1_rvalid_o(req1_rvalid_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o), .cs_o(cs_o),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
    endtask

    task automatic check_model();
        chk("cs",     cs_o,    m_owner >= 0);
        chk("grant",  grant_o, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
        chk("busy",   busy_o,  (m_owner >= 0) || (m_gap > 0));
        chk("addr",   addr_o,  m_addr);
        chk("wdata",  wdata_o, m_wdata);
        chk("we",     we_o,    m_we);
        chk("rvalid0", req0_rvalid_o, rvalid_i && (m_owner == 0));
        chk("rvalid1", req1_rvalid_o, rvalid_i && (m_owner == 1));
        chk("rdata0", req0_rdata_o, (m_owner == 0) ? rdata_i : {DW{1'b0}});
        chk("rdata1", req1_rdata_o, (m_owner == 1) ? rdata_i : {DW{1'b0}});
    endtask

    task automatic model_advance();
        if (m_owner >= 0) begin
            if (rvalid_i) begin
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
        end else if (req0_cs_i || req1_cs_i) begin
            int w;
            w = (req0_cs_i && req1_cs_i) ? 1 - m_last : (req0_cs_i ? 0 : 1);
            m_owner = w;
            m_last  = w;
            m_addr  = (w == 0) ? req0_addr_i  : req1_addr_i;
            m_wdata = (w == 0) ? req0_wdata_i : req1_wdata_i;
            m_we    = (w == 0) ? req0_we_i    : req1_we_i;
        end
    endtask

    // One clock cycle: settle, compare against the model, advance model, cross the edge.
    task automatic cyc();
        #2;
        check_model();
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_model();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    logic d0, d1;

    initial begin
        req0_cs_i = 0; req0_we_i = 0; req0_addr_i = '0; req0_wdata_i = '0;
        req1_cs_i = 0; req1_we_i = 0; req1_addr_i = '0; req1_wdata_i = '0;
        rdata_i = '0; rvalid_i = 0;
        model_reset();
        #2;
        check_model();
        do_reset();

        // Single read from req0.
        req0_cs_i = 1; req0_addr_i = 32'h1000; req0_we_i = 0;
        cyc();
        rvalid_i = 1; rdata_i = {4{32'hDEADBEEF}};
        #1;
        chk("t1_cs", cs_o, 1'b1);
        chk("t1_addr", addr_o, 32'h1000);
        chk("t1_rvalid0", req0_rvalid_o, 1'b1);
        chk("t1_rdata0", req0_rdata_o, {4{32'hDEADBEEF}});
        chk("t1_rvalid1", req1_rvalid_o, 1'b0);
        cyc();
        rvalid_i = 0; req0_cs_i = 0;
        #1;
        chk("t1_cs_after", cs_o, 1'b0);
        cyc();
        cyc();

        // Tie from reset: alternation starting with req0.
        do_reset();
        req0_cs_i = 1; req0_addr_i = 32'h100;
        req1_cs_i = 1; req1_addr_i = 32'h200;
        cyc();
        for (int i = 0; i < 6; i++) begin
            rvalid_i = 1; rdata_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("alt_grant", grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_addr", addr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
            cyc();
            rvalid_i = 0;
            cyc();
            cyc();
        end
        rvalid_i = 1;
        cyc();
        rvalid_i = 0; req0_cs_i = 0; req1_cs_i = 0;
        cyc();
        cyc();

        // Attribute stability while BUSY.
        req1_cs_i = 1; req1_addr_i = 32'h2000; req1_wdata_i = {DW{1'b1}}; req1_we_i = 1;
        cyc();
        req1_addr_i = 32'h3000; req1_wdata_i = '0; req1_we_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stab_addr", addr_o, 32'h2000);
            chk("stab_wdata", wdata_o, {DW{1'b1}});
            chk("stab_we", we_o, 1'b1);
            cyc();
        end
        rvalid_i = 1;
        cyc();
        rvalid_i = 0; req1_cs_i = 0;
        #1;
        chk("stab_addr_done", addr_o, 32'h2000);
        cyc();

        // Stray completions in IDLE and DONE.
        rvalid_i = 1;
        #1;
        chk("spur_idle_rv0", req0_rvalid_o, 1'b0);
        chk("spur_idle_rv1", req1_rvalid_o, 1'b0);
        cyc();
        #1;
        chk("spur_idle_busy", busy_o, 1'b0);
        rvalid_i = 0; req0_cs_i = 1; req0_addr_i = 32'h40;
        cyc();
        rvalid_i = 1;
        cyc();
        req0_cs_i = 0;
        #1;
        chk("spur_done_rv0", req0_rvalid_o, 1'b0);
        cyc();
        rvalid_i = 0;
        #1;
        chk("spur_done_next_busy", busy_o, 1'b0);
        cyc();

        // Reset while BUSY (req1 wins this tie since req0 went last).
        req0_cs_i = 1; req1_cs_i = 1;
        cyc();
        cyc();
        rvalid_i = 1;
        rst_ni = 0;
        #1;
        model_reset();
        chk("rst_cs", cs_o, 1'b0);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_rv1", req1_rvalid_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1; rvalid_i = 0;
        cyc();
        #1;
        chk("rst_tie_req0", grant_o, 2'b01);
        rvalid_i = 1;
        cyc();
        rvalid_i = 0; req0_cs_i = 0; req1_cs_i = 0;
        cyc();
        cyc();

        // Held cs: next req0 grant after one DONE and one IDLE cycle.
        req0_cs_i = 1; req0_addr_i = 32'h80;
        cyc();
        rvalid_i = 1;
        cyc();
        rvalid_i = 0;
        #1;
        chk("held_done_cs", cs_o, 1'b0);
        cyc();
        #1;
        chk("held_idle_cs", cs_o, 1'b0);
        chk("held_idle_busy", busy_o, 1'b0);
        cyc();
        #1;
        chk("held_regrant_cs", cs_o, 1'b1);
        chk("held_regrant_grant", grant_o, 2'b01);
        rvalid_i = 1;
        cyc();
        rvalid_i = 0; req0_cs_i = 0;
        cyc();
        cyc();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rvalid_i = ($urandom_range(0, 2) == 0);
            rdata_i  = {$urandom, $urandom, $urandom, $urandom};
            if (!req0_cs_i && $urandom_range(0, 3) == 0) req0_cs_i = 1;
            if (!req1_cs_i && $urandom_range(0, 3) == 0) req1_cs_i = 1;
            if ($urandom_range(0, 1) == 1) begin
                req0_addr_i = $urandom; req0_we_i = 1'($urandom_range(0, 1));
                req0_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if ($urandom_range(0, 1) == 1) begin
                req1_addr_i = $urandom; req1_we_i = 1'($urandom_range(0, 1));
                req1_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end
            d0 = rvalid_i && (m_owner == 0);
            d1 = rvalid_i && (m_owner == 1);
            cyc();
            if (d0 && $urandom_range(0, 1) == 1) req0_cs_i = 0;
            if (d1 && $urandom_range(0, 1) == 1) req1_cs_i = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
